// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a ready handshake and
// a bounded memory wait. It also keeps a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        illegal_op,
  output logic        bus_fault,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R  = 3'd0,
    CLS_I  = 3'd1,
    CLS_LD = 3'd2,
    CLS_ST = 3'd3,
    CLS_BR = 3'd4
  } cls_t;

  state_t             st;
  state_t             st_nxt;
  cls_t               cls;
  cls_t               cls_dec;
  logic               dec_legal;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout_c;
  logic               retire_c;
  logic               fault_c;
  logic               wait_clr_c;

  assign state     = st;
  assign timeout_c = (wait_cnt >= WAIT_W'(TIMEOUT));

  // Opcode to instruction class
  always_comb begin
    dec_legal = 1'b1;
    cls_dec   = CLS_R;
    case (opcode)
      OP_R:    cls_dec = CLS_R;
      OP_I:    cls_dec = CLS_I;
      OP_LD:   cls_dec = CLS_LD;
      OP_ST:   cls_dec = CLS_ST;
      OP_BR:   cls_dec = CLS_BR;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next state, retire and fault detection; mem_ready wins over the timeout
  always_comb begin
    st_nxt   = st;
    retire_c = 1'b0;
    fault_c  = 1'b0;
    case (st)
      FETCH: begin
        if (mem_ready) begin
          st_nxt = DECODE;
        end else if (timeout_c) begin
          st_nxt  = TRAP;
          fault_c = 1'b1;
        end
      end
      DECODE: st_nxt = dec_legal ? EXEC : TRAP;
      EXEC: begin
        case (cls)
          CLS_R, CLS_I:   st_nxt = WB;
          CLS_LD, CLS_ST: st_nxt = MEM;
          CLS_BR: begin
            st_nxt   = FETCH;
            retire_c = 1'b1;
          end
          default:        st_nxt = TRAP;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (cls == CLS_LD) begin
            st_nxt = WB;
          end else begin
            st_nxt   = FETCH;
            retire_c = 1'b1;
          end
        end else if (timeout_c) begin
          st_nxt  = TRAP;
          fault_c = 1'b1;
        end
      end
      WB: begin
        st_nxt   = FETCH;
        retire_c = 1'b1;
      end
      TRAP:    st_nxt = TRAP;
      default: st_nxt = TRAP;
    endcase
  end

  assign wait_clr_c = mem_ready ||
                      ((st_nxt != st) && ((st_nxt == FETCH) || (st_nxt == MEM)));

  // State, class, wait counter, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= FETCH;
      cls        <= CLS_R;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      bus_fault  <= 1'b0;
      instret    <= '0;
    end else begin
      st <= st_nxt;
      if (st == DECODE && dec_legal) begin
        cls <= cls_dec;
      end
      if (st == DECODE && !dec_legal) begin
        illegal_op <= 1'b1;
      end
      if (fault_c) begin
        bus_fault <= 1'b1;
      end
      if (wait_clr_c) begin
        wait_cnt <= '0;
      end else if (st == FETCH || st == MEM) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire_c) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  // Datapath strobes; all forced low while reset is held
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    if (reset) begin
      case (st)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        EXEC: begin
          case (cls)
            CLS_R: alu_op = 2'b10;
            CLS_I: begin
              alu_src = 1'b1;
              alu_op  = 2'b10;
            end
            CLS_LD, CLS_ST: alu_src = 1'b1;
            CLS_BR: begin
              alu_op = 2'b01;
              if (zero) begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
              end
            end
            default: alu_op = 2'b00;
          endcase
        end
        MEM: begin
          if (cls == CLS_LD) begin
            mem_read = 1'b1;
          end else if (cls == CLS_ST) begin
            mem_write = 1'b1;
          end
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == CLS_LD);
        end
        default: reg_write = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its expected
// cycle schedule from class and memory wait counts, then played against the DUT.
module tb_multicycle_control_fsm;

  localparam int unsigned TIMEOUT = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] sv;
    logic       rdy;
    logic       z;
    logic       dec;
    logic       retire;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write;
  logic        mem_to_reg, alu_src, reg_write, illegal_op, bus_fault;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [9:0]  strobes;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = 32'd0;

  multicycle_control_fsm #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .illegal_op(illegal_op), .bus_fault(bus_fault),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  assign strobes = {pc_write, pc_src, ir_write, mem_read, mem_write,
                    mem_to_reg, alu_src, alu_op, reg_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk(input logic pw, input logic ps, input logic irw,
                                    input logic mr, input logic mw, input logic m2r,
                                    input logic as, input logic [1:0] aop, input logic rw);
    return {pw, ps, irw, mr, mw, m2r, as, aop, rw};
  endfunction

  function automatic cyc_t cy(input logic [2:0] st, input logic [9:0] sv, input logic rdy,
                              input logic z, input logic dec, input logic retire);
    cyc_t c;
    c.st = st; c.sv = sv; c.rdy = rdy; c.z = z; c.dec = dec; c.retire = retire;
    return c;
  endfunction

  // 0 R, 1 I, 2 LD, 3 ST, 4 BR, -1 unsupported
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      OP_R:    return 0;
      OP_I:    return 1;
      OP_LD:   return 2;
      OP_ST:   return 3;
      OP_BR:   return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Reset held for n edges; strobes must be low while reset is low
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      reset = 1'b0;
      mem_ready = rb();
      zero = rb();
      opcode = 7'($urandom);
      #2;
      check("rst_strobes", 32'(strobes), 32'd0);
      @(posedge clk);
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_flags", 32'({illegal_op, bus_fault}), 32'd0);
    end
    reset = 1'b1;
    exp_instret = 32'd0;
  endtask

  // fw/mw = wait cycles before mem_ready in FETCH/MEM; abort_at = cycle index to reset at
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                           input int abort_at, output logic trapped);
    cyc_t q[$];
    int   cl;
    logic t_ill;
    logic t_bus;
    cl    = cls_of(op);
    t_ill = (cl < 0);
    t_bus = 1'b0;
    for (int k = 0; k <= fw; k++) begin
      if (k == fw) begin
        q.push_back(cy(3'd0, mk(1, 0, 1, 1, 0, 0, 0, 2'b00, 0), 1'b1, rb(), 1'b0, 1'b0));
      end else begin
        q.push_back(cy(3'd0, mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 0), 1'b0, rb(), 1'b0, 1'b0));
        if (k == int'(TIMEOUT)) begin
          t_bus = 1'b1;
          break;
        end
      end
    end
    if (!t_bus) begin
      q.push_back(cy(3'd1, 10'd0, rb(), rb(), 1'b1, 1'b0));
    end
    if (!t_bus && !t_ill) begin
      case (cl)
        0: q.push_back(cy(3'd2, mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 0), rb(), rb(), 1'b0, 1'b0));
        1: q.push_back(cy(3'd2, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0), rb(), rb(), 1'b0, 1'b0));
        2, 3: q.push_back(cy(3'd2, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0), rb(), rb(), 1'b0, 1'b0));
        default: q.push_back(cy(3'd2, mk(z, z, 0, 0, 0, 0, 0, 2'b01, 0), rb(), z, 1'b0, 1'b1));
      endcase
      if (cl == 2 || cl == 3) begin
        for (int k = 0; k <= mw; k++) begin
          q.push_back(cy(3'd3, mk(0, 0, 0, cl == 2, cl == 3, 0, 0, 2'b00, 0),
                         k == mw, rb(), 1'b0, (k == mw) && (cl == 3)));
          if (k != mw && k == int'(TIMEOUT)) begin
            t_bus = 1'b1;
            break;
          end
        end
      end
      if (!t_bus && cl != 3 && cl != 4) begin
        q.push_back(cy(3'd4, mk(0, 0, 0, 0, 0, cl == 2, 0, 2'b00, 1), rb(), rb(), 1'b0, 1'b1));
      end
    end
    if (t_ill || t_bus) begin
      for (int k = 0; k < (t_ill ? 22 : 4); k++) begin
        q.push_back(cy(3'd5, 10'd0, rb(), rb(), 1'b0, 1'b0));
      end
    end
    trapped = t_ill || t_bus;
    foreach (q[i]) begin
      if (i == abort_at) begin
        reset = 1'b0;
        mem_ready = 1'b1;
        opcode = op;
        #2;
        check("abort_strobes", 32'(strobes), 32'd0);
        @(posedge clk);
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_instret", instret, 32'd0);
        reset = 1'b1;
        exp_instret = 32'd0;
        trapped = 1'b0;
        return;
      end
      opcode = q[i].dec ? op : 7'($urandom);
      mem_ready = q[i].rdy;
      zero = q[i].z;
      #2;
      check("state", 32'(state), 32'(q[i].st));
      check("strobes", 32'(strobes), 32'(q[i].sv));
      @(posedge clk);
      if (q[i].retire) exp_instret = exp_instret + 32'd1;
      #1;
      check("instret", instret, exp_instret);
    end
    check("flags", 32'({illegal_op, bus_fault}), 32'({t_ill, t_bus}));
  endtask

  initial begin
    logic       trapped;
    logic [6:0] op;
    int         r;
    int         fw;
    int         mw;
    reset = 1'b0;
    opcode = 7'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(OP_R, 0, 0, 1'b0, -1, trapped);
    run_instr(OP_I, 2, 0, 1'b0, -1, trapped);
    run_instr(OP_LD, 0, 3, 1'b0, -1, trapped);
    run_instr(OP_ST, 0, 3, 1'b0, -1, trapped);
    run_instr(OP_BR, 0, 0, 1'b1, -1, trapped);
    run_instr(OP_BR, 0, 0, 1'b0, -1, trapped);
    run_instr(OP_R, int'(TIMEOUT), 0, 1'b0, -1, trapped);
    run_instr(OP_ST, 1, int'(TIMEOUT), 1'b0, -1, trapped);
    run_instr(OP_LD, 0, 3, 1'b0, 4, trapped);

    run_instr(OP_BAD, 0, 0, 1'b0, -1, trapped);
    do_reset(1);
    run_instr(OP_R, int'(TIMEOUT) + 1, 0, 1'b0, -1, trapped);
    do_reset(1);
    run_instr(OP_LD, 0, int'(TIMEOUT) + 1, 1'b0, -1, trapped);
    do_reset(1);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        op = 7'($urandom);
        while (cls_of(op) >= 0) op = 7'($urandom);
      end else begin
        case (r % 5)
          0: op = OP_R;
          1: op = OP_I;
          2: op = OP_LD;
          3: op = OP_ST;
          default: op = OP_BR;
        endcase
      end
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                       : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                       : $urandom_range(0, 3);
      run_instr(op, fw, mw, rb(), ($urandom_range(0, 29) == 0) ? 3 : -1, trapped);
      if (trapped) do_reset(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
